debounce_array: RTL and testbench
=================================

Name: debounce_array

Overview:
- N-channel button conditioner that replaces per-button single-channel debouncers in the player-input path.
- Each channel has a 2-FF synchroniser, optional per-channel polarity inversion, a debounce counter driven by a shared prescaler tick, and edge and long-press event generation.
- Outputs feed game control logic directly: debounced levels, one-cycle rise/fall pulses and long-press pulses.

Parameters:
N_CH, 6, number of independent input channels (>=1)
TICK_DIV, 100000, clk cycles per debounce tick (>=1; 1 = tick every cycle; 100000 = 1 ms at 100 MHz)
STABLE_TICKS, 10, consecutive ticks an input must differ from the debounced level before it is accepted (>=1)
HOLD_TICKS, 1000, ticks a debounced 1 must persist to fire a long-press pulse (0 = long-press disabled)
INV_MASK, {N_CH{1'b0}}, bit i = 1 inverts raw input i before synchronisation (active-low buttons)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
btn_in  input  N_CH  raw asynchronous button inputs
level  output  N_CH  debounced, polarity-corrected level
rise  output  N_CH  one-cycle pulse on debounced 0->1
fall  output  N_CH  one-cycle pulse on debounced 1->0
long_press  output  N_CH  one-cycle pulse when level has been 1 for HOLD_TICKS ticks
tick  output  1  shared prescaler tick (observability)

Behaviour:
- Reset (async assert, sync release): prescaler, synchroniser FFs, debounce counters, hold counters and all outputs go to 0. Reset mid-bounce discards partial counts.
- Prescaler:
  - pcnt counts 0..TICK_DIV-1 and wraps.
  - tick = (pcnt == TICK_DIV-1), combinational, exactly one cycle per period. With TICK_DIV=1, tick is constantly 1.
- Input path:
  - x_i = btn_in[i] ^ INV_MASK[i].
  - Two FFs produce s_i, so s_i lags x_i by 2 clk cycles.
- Debounce, per channel. Counter dcnt width is clog2(STABLE_TICKS+1). Rules apply in this priority order:
  - s_i == level[i]: dcnt <= 0 on any cycle, tick or not.
  - s_i != level[i] and tick and dcnt == STABLE_TICKS-1: level[i] <= s_i, dcnt <= 0.
  - s_i != level[i] and tick, otherwise: dcnt <= dcnt+1.
  - s_i != level[i] and no tick: hold dcnt.
- Acceptance latency after a clean step on btn_in: from 2+(STABLE_TICKS-1)*TICK_DIV+1 to 2+STABLE_TICKS*TICK_DIV clk cycles, depending on prescaler phase.
- Any glitch back to level before acceptance restarts the count.
- rise/fall:
  - Registered and asserted in the same cycle level[i] changes, for exactly one cycle.
  - rise and fall are never both high on the same channel.
- Long-press, per channel. Counter hcnt width is clog2(HOLD_TICKS+1).
  - level[i] = 0: hcnt <= 0.
  - level[i] = 1 and tick and hcnt < HOLD_TICKS: hcnt <= hcnt+1.
  - long_press[i] pulses for one cycle in the cycle after hcnt becomes HOLD_TICKS.
  - Saturates: no repeat until level drops to 0 and a new press completes.
  - HOLD_TICKS=0: long_press tied to 0, hcnt logic removed.
- Channels are fully independent. Simultaneous events on any channel subset are all reported in the same cycle.
- No combinational path from btn_in to any output.

Test Plan (bench params: N_CH=2, TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=5, INV_MASK=2'b10):
- Reset values: hold rst_n=0 with btn_in=2'b00 -> level=2'b10 never appears during reset; all outputs 0. After release, ch1 (inverted, raw 0 -> x=1) accepts: level[1]=1 and rise[1] pulse within 2+12 cycles. Ch0 stays 0.
- Clean press ch0: btn_in[0] 0->1 held -> level[0]=1 between cycle 11 and 14 after the edge; rise[0] high exactly one cycle; fall stays 0.
- Bounce rejection: btn_in[0] toggles 1 for 6 cycles, then 0 for 2, repeated 5 times -> level[0] stays 0, no rise. A final stable 1 -> accepted 11-14 cycles after the last edge.
- Long-press: hold ch0 debounced high -> long_press[0] pulses once, 5 ticks (20±4 cycles) after rise. Holding a further 100 cycles gives no second pulse. Release -> fall[0] pulse. A re-press fires long_press again.
- Simultaneous edges: both channels change on the same cycle -> rise[0] and fall[1] asserted in the same cycle.
- Reset mid-count: assert rst_n=0 two ticks into a ch0 acceptance, then release -> count restarts. Acceptance takes the full 11-14 cycles after release plus sync.

Source files
------------

// File: rtl/debounce_array.sv
// rtl/debounce_array.sv - N-channel button conditioner: sync, debounce, edge and long-press events
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   btn_in      raw asynchronous button inputs, one bit per channel
//   level       debounced, polarity-corrected level per channel
//   rise        one-cycle pulse when level goes 0->1
//   fall        one-cycle pulse when level goes 1->0
//   long_press  one-cycle pulse once level has been 1 for HOLD_TICKS ticks
//   tick        shared debounce prescaler tick
module debounce_array #(
  parameter int              N_CH         = 6,
  parameter int              TICK_DIV     = 100000,
  parameter int              STABLE_TICKS = 10,
  parameter int              HOLD_TICKS   = 1000,
  parameter logic [N_CH-1:0] INV_MASK     = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press,
  output logic            tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(STABLE_TICKS - 1);

  // Shared prescaler. With TICK_DIV=1, P_LAST is 0 so tick stays high.
  logic [PW-1:0] pcnt;

  assign tick = (pcnt == P_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Polarity correction happens before the synchroniser so the inversion
  // is a pure constant XOR and adds no logic after the second flop.
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= btn_in ^ INV_MASK;
      s     <= sync1;
    end
  end

  // Debounce: dcnt counts ticks for which s has disagreed with level without
  // interruption. Any cycle of agreement (tick or not) clears it, so a glitch
  // back to the current level restarts the acceptance window.
  logic [DW-1:0] dcnt [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        dcnt[i] <= '0;
      end
      level <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (s[i] == level[i]) begin
          dcnt[i] <= '0;
        end else if (tick) begin
          if (dcnt[i] == D_LAST) begin
            level[i] <= s[i];
            dcnt[i]  <= '0;
            rise[i]  <= s[i];
            fall[i]  <= ~s[i];
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Long-press: hcnt saturates at HOLD_TICKS while level stays 1. at_max_q
  // remembers that the saturated value was already seen, so the pulse fires
  // exactly once, one cycle after saturation, until level drops and re-arms.
  if (HOLD_TICKS > 0) begin : g_long
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] H_MAX = HW'(HOLD_TICKS);

    logic [HW-1:0]   hcnt [N_CH];
    logic [N_CH-1:0] at_max_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < N_CH; i++) begin
          hcnt[i] <= '0;
        end
        at_max_q   <= '0;
        long_press <= '0;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (!level[i]) begin
            hcnt[i] <= '0;
          end else if (tick && (hcnt[i] < H_MAX)) begin
            hcnt[i] <= hcnt[i] + 1'b1;
          end
          at_max_q[i]   <= (hcnt[i] == H_MAX);
          long_press[i] <= (hcnt[i] == H_MAX) && !at_max_q[i];
        end
      end
    end
  end else begin : g_no_long
    assign long_press = '0;
  end

endmodule

// File: tb/tb_debounce_array.sv
// tb/tb_debounce_array.sv - self-checking bench for debounce_array
module tb_debounce_array;

  localparam int N_CH = 2;
  localparam int TD   = 4;
  localparam int ST   = 3;
  localparam int HOLD = 5;
  localparam logic [1:0] INV = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_in;
  logic [1:0] level, rise, fall, long_press;
  logic       tick;

  always #5 clk = ~clk;

  debounce_array #(
    .N_CH(N_CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .HOLD_TICKS(HOLD), .INV_MASK(INV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .level(level), .rise(rise),
    .fall(fall), .long_press(long_press), .tick(tick)
  );

  int checks = 0;
  int errs = 0;
  int rise0_cnt = 0;
  int lp0_cnt = 0;

  // Behavioural model: cycles since reset give the tick phase, a two-entry
  // history gives the synchronised input, and per-channel integers count
  // disagreeing ticks and ticks spent high.
  int         cyc = 0;
  logic [1:0] m_d1 = '0, m_d2 = '0;
  logic [1:0] m_level = '0, m_rise = '0, m_fall = '0, m_lp = '0;
  int         m_run [2] = '{0, 0};
  int         m_high [2] = '{0, 0};
  bit         m_pend [2] = '{0, 0};

  initial begin : model
    bit t;
    bit old_lvl;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0; m_d1 = '0; m_d2 = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_lp = '0;
        for (int c = 0; c < 2; c++) begin
          m_run[c] = 0; m_high[c] = 0; m_pend[c] = 0;
        end
      end else begin
        t = ((cyc % TD) == TD - 1);
        for (int c = 0; c < 2; c++) begin
          old_lvl = m_level[c];
          m_lp[c] = m_pend[c];
          m_pend[c] = 0;
          if (!old_lvl) m_high[c] = 0;
          else if (t && m_high[c] < HOLD) begin
            m_high[c]++;
            if (m_high[c] == HOLD) m_pend[c] = 1;
          end
          m_rise[c] = 1'b0;
          m_fall[c] = 1'b0;
          if (m_d2[c] == old_lvl) m_run[c] = 0;
          else if (t) begin
            m_run[c]++;
            if (m_run[c] == ST) begin
              m_level[c] = m_d2[c];
              m_run[c] = 0;
              m_rise[c] = m_d2[c];
              m_fall[c] = ~m_d2[c];
            end
          end
        end
        m_d2 = m_d1;
        m_d1 = btn_in ^ INV;
        cyc++;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin : compare
    logic [8:0] act, exp;
    forever begin
      @(negedge clk);
      act = {level, rise, fall, long_press, tick};
      exp = {m_level, m_rise, m_fall, m_lp, ((cyc % TD) == TD - 1)};
      checks++;
      if (act !== exp) begin
        errs++;
        if (errs <= 30)
          $display("FAIL model_cmp t=%0t {lvl,rise,fall,lp,tick} got %b expected %b", $time, act, exp);
      end
      if (rise[0] === 1'b1) rise0_cnt++;
      if (long_press[0] === 1'b1) lp0_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] sig(input int sel);
    case (sel)
      0: return level;
      1: return rise;
      2: return fall;
      default: return long_press;
    endcase
  endfunction

  // Counts clock edges until the selected bit is seen high; checks the count.
  task automatic wait_pulse(input int sel, input int ch, input int lo, input int hi, input string name);
    int n;
    bit seen;
    logic [1:0] v;
    n = 0;
    seen = 0;
    while (!seen && n < hi + 6) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      v = sig(sel);
      if (v[ch] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n < lo || n > hi) begin
      errs++;
      $display("FAIL %s: got %0d cycles (seen=%0b) expected %0d..%0d", name, n, seen, lo, hi);
    end
  endtask

  task automatic run(input logic [1:0] v, input int ncyc);
    @(posedge clk);
    #2 btn_in = v;
    repeat (ncyc - 1) @(posedge clk);
  endtask

  initial begin : stim
    int c0;
    btn_in = 2'b00;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_outputs", {level, rise, fall, long_press, tick}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    wait_pulse(0, 1, 11, 14, "ch1_inverted_accept");
    chk("ch1_rise_with_level", rise[1], 1);
    chk("ch0_idle_after_reset", level[0], 0);
    repeat (10) @(posedge clk);

    run(2'b01, 1);
    wait_pulse(1, 0, 11, 14, "ch0_clean_rise");
    @(negedge clk);
    chk("ch0_rise_one_cycle", rise[0], 0);
    chk("ch0_no_fall_on_press", fall[0], 0);
    wait_pulse(3, 0, 16, 24, "ch0_long_press");
    @(posedge clk);
    c0 = lp0_cnt;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("no_repeat_long_press", lp0_cnt - c0, 0);
    run(2'b00, 1);
    wait_pulse(2, 0, 11, 14, "ch0_release_fall");
    repeat (10) @(posedge clk);

    c0 = rise0_cnt;
    repeat (5) begin
      run(2'b01, 6);
      run(2'b00, 2);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bounce_no_rise", rise0_cnt - c0, 0);
    chk("bounce_level_low", level[0], 0);
    run(2'b01, 1);
    wait_pulse(1, 0, 11, 14, "bounce_final_accept");
    wait_pulse(3, 0, 16, 24, "ch0_repress_long_press");
    run(2'b00, 1);
    wait_pulse(2, 0, 11, 14, "ch0_fall_2");
    repeat (10) @(posedge clk);

    run(2'b11, 1);
    wait_pulse(1, 0, 11, 14, "simul_rise0");
    chk("simul_fall1", fall[1], 1);
    repeat (10) @(posedge clk);
    run(2'b10, 1);
    wait_pulse(2, 0, 11, 14, "ch0_fall_3");
    repeat (10) @(posedge clk);

    run(2'b11, 1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("midcount_not_yet", level[0], 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midcount_reset_clears", {level, rise, fall, long_press, tick}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_pulse(1, 0, 11, 14, "post_reset_full_count");

    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
